// File: rtl/mcc_pkg.sv
// mcc_pkg: shared definitions for the multi-cycle MIPS-subset core.
//  - opcode / funct encodings of the supported ISA subset
//  - FSM state codes, ALU operation and mux-select enums
//  - ctrl_t: per-cycle datapath control bundle from mcc_control to mcc_core
//  - helpers: imm16 sign extension, R-type funct legality and ALU op decode
package mcc_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd2;
  localparam logic [STATE_W-1:0] S_ALUWB  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd5;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd6;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd7;
  localparam logic [STATE_W-1:0] S_ADDIEX = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDIWB = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP   = 4'd11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_e;

  typedef struct packed {
    logic      pc_we;
    pc_src_e   pc_src;
    logic      ir_we;
    logic      ab_we;
    logic      aluout_we;
    logic      mdr_we;
    logic      rf_we;
    logic      rf_dst_rd;   // 1: rd field, 0: rt field
    logic      rf_src_mem;  // 1: MDR, 0: ALUOut
    logic      alu_a_pc;    // 1: PC, 0: A register
    alu_srcb_e alu_b_sel;
    alu_op_e   alu_op;
    logic      iord;        // 1: memory address from ALUOut, 0: from PC
  } ctrl_t;

  function automatic logic [XLEN-1:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic alu_op_e funct_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcc_control.sv
// mcc_control: multi-cycle FSM of the core.
// Ports:
//  clk, reset        clock, synchronous active-high reset
//  opcode_i/funct_i  fields of the instruction register
//  zero_i            ALU result equals zero (beq compare)
//  mem_ready_i       memory access completes this cycle
//  ctrl_o            datapath enables, mux selects, ALU op
//  mem_req_o/we_o    memory handshake, decoded from state
//  illegal_o         one-cycle pulse in DECODE on unsupported opcode/funct
//  retire_o          final cycle of a legal instruction (only with MCC_PERF_COUNTERS_EN)
module mcc_control
  import mcc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       illegal_o
`ifdef MCC_PERF_COUNTERS_EN
  ,
  output logic       retire_o
`endif
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and per-state control decode
  always_comb begin
    state_d   = state_q;
    ctrl_o    = '0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o        = 1'b1;
        ctrl_o.alu_a_pc  = 1'b1;
        ctrl_o.alu_b_sel = SRCB_FOUR;
        if (mem_ready_i) begin
          ctrl_o.ir_we  = 1'b1;
          ctrl_o.pc_we  = 1'b1;
          ctrl_o.pc_src = PCSRC_ALU;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively while the ALU is otherwise idle
        ctrl_o.ab_we     = 1'b1;
        ctrl_o.alu_a_pc  = 1'b1;
        ctrl_o.alu_b_sel = SRCB_IMM_SH2;
        ctrl_o.aluout_we = 1'b1;
        case (opcode_i)
          OP_RTYPE: begin
            if (funct_legal(funct_i)) begin
              state_d = S_EXEC;
            end else begin
              illegal_o = 1'b1;
              state_d   = S_FETCH;
            end
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ctrl_o.alu_b_sel = SRCB_REG;
        ctrl_o.alu_op    = funct_alu_op(funct_i);
        ctrl_o.aluout_we = 1'b1;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_o.rf_we     = 1'b1;
        ctrl_o.rf_dst_rd = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMADR: begin
        ctrl_o.alu_b_sel = SRCB_IMM;
        ctrl_o.aluout_we = 1'b1;
        state_d          = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_o   = 1'b1;
        ctrl_o.iord = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.mdr_we = 1'b1;
          state_d       = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.rf_src_mem = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        ctrl_o.iord = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl_o.alu_b_sel = SRCB_IMM;
        ctrl_o.aluout_we = 1'b1;
        state_d          = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_o.rf_we = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_o.alu_b_sel = SRCB_REG;
        ctrl_o.alu_op    = ALU_SUB;
        if (zero_i) begin
          ctrl_o.pc_we  = 1'b1;
          ctrl_o.pc_src = PCSRC_ALUOUT;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.pc_src = PCSRC_JUMP;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Nothing leaves the core while reset is asserted
    if (reset) begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      illegal_o = 1'b0;
    end
  end

`ifdef MCC_PERF_COUNTERS_EN
  // Final state of each legal instruction; a store retires when its write completes
  assign retire_o = (state_q == S_ALUWB)  || (state_q == S_MEMWB) ||
                    (state_q == S_ADDIWB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP)   || ((state_q == S_MEMWR) && mem_ready_i);
`endif

endmodule

// File: rtl/mcc_core.sv
// mcc_core: multi-cycle MIPS-subset CPU with one shared ALU and a unified
// req/ready memory port (wait states allowed).
// Parameters: ADDR_W (PC / address width), RESET_PC, NREGS (power of 2, <= 32).
// Ports:
//  clk, reset                  clock, synchronous active-high reset
//  mem_req/mem_we/mem_addr     memory request, held until mem_req && mem_ready
//  mem_wdata                   store data
//  mem_rdata/mem_ready         read data and completion
//  illegal_instr               one-cycle pulse on an unsupported instruction
//  cycle_count/instret_count   performance counters
// Build option: MCC_PERF_COUNTERS_EN enables the counters; otherwise both read 0.
module mcc_core
  import mcc_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          NREGS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              illegal_instr,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instret_count
);

  // ALU is at least as wide as the PC so PC arithmetic wraps mod 2^ADDR_W
  localparam int unsigned ALU_W  = (ADDR_W > XLEN) ? ADDR_W : XLEN;
  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  ctrl_t             ctrl;
  logic              zero;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0]   ir_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [ALU_W-1:0]  aluout_q;
  logic [XLEN-1:0]   mdr_q;
  logic [XLEN-1:0]   rf_q [NREGS];

  logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [XLEN-1:0]   wb_data;
  logic [ALU_W-1:0]  imm_ext, pc_ext, jump_tgt;
  logic [ALU_W-1:0]  alu_a, alu_b, alu_res;
  logic              slt_c;

`ifdef MCC_PERF_COUNTERS_EN
  logic retire;
`endif

  mcc_control u_control (
    .clk         (clk),
    .reset       (reset),
    .opcode_i    (ir_q[31:26]),
    .funct_i     (ir_q[5:0]),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .illegal_o   (illegal_instr)
`ifdef MCC_PERF_COUNTERS_EN
    ,
    .retire_o    (retire)
`endif
  );

  // Register indices use the low log2(NREGS) bits of each field
  assign rs_idx = RIDX_W'(ir_q[25:21]);
  assign rt_idx = RIDX_W'(ir_q[20:16]);
  assign rd_idx = RIDX_W'(ir_q[15:11]);
  assign wb_idx = ctrl.rf_dst_rd ? rd_idx : rt_idx;
  assign wb_data = ctrl.rf_src_mem ? mdr_q : aluout_q[XLEN-1:0];

  assign imm_ext  = ALU_W'($signed(sext_imm16(ir_q[15:0])));
  assign pc_ext   = ALU_W'(pc_q);
  // PC already holds PC+4 when the jump executes
  assign jump_tgt = {pc_ext[ALU_W-1:28], ir_q[25:0], 2'b00};

  // Shared ALU operand selection and operation
  always_comb begin
    alu_a = ctrl.alu_a_pc ? pc_ext : ALU_W'(a_q);
    case (ctrl.alu_b_sel)
      SRCB_REG:     alu_b = ALU_W'(b_q);
      SRCB_FOUR:    alu_b = ALU_W'(4);
      SRCB_IMM:     alu_b = imm_ext;
      SRCB_IMM_SH2: alu_b = imm_ext << 2;
      default:      alu_b = '0;
    endcase
    slt_c = $signed(alu_a[XLEN-1:0]) < $signed(alu_b[XLEN-1:0]);
    case (ctrl.alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = ALU_W'(slt_c);
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res[XLEN-1:0] == '0);

  // Next PC source
  always_comb begin
    case (ctrl.pc_src)
      PCSRC_ALU:    pc_d = ADDR_W'(alu_res);
      PCSRC_ALUOUT: pc_d = ADDR_W'(aluout_q);
      PCSRC_JUMP:   pc_d = ADDR_W'(jump_tgt);
      default:      pc_d = pc_q;
    endcase
  end

  assign mem_addr  = ctrl.iord ? ADDR_W'(aluout_q) : pc_q;
  assign mem_wdata = b_q;

  // Architectural and inter-state datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      if (ctrl.pc_we)     pc_q     <= pc_d;
      if (ctrl.ir_we)     ir_q     <= mem_rdata;
      if (ctrl.ab_we) begin
        a_q <= rf_q[rs_idx];
        b_q <= rf_q[rt_idx];
      end
      if (ctrl.aluout_we) aluout_q <= alu_res;
      if (ctrl.mdr_we)    mdr_q    <= mem_rdata;
      // Register 0 is never written, so it keeps reading zero
      if (ctrl.rf_we && (wb_idx != '0)) rf_q[wb_idx] <= wb_data;
    end
  end

`ifdef MCC_PERF_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;

  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = 32'd0;
  assign instret_count = 32'd0;
`endif

endmodule
